// File: rtl/func_arbiter.sv
// func_arbiter: round-robin scheduler sharing one func unit (y = a^3 + isqrt(b))
// among N_REQ requesters. Latches the winner's operands, sequences the
// start/busy handshake, and returns the result with a one-cycle done pulse
// to the owning requester.
// Optional watchdog: define FUNC_ARB_TIMEOUT_EN to abort an operation after
// TIMEOUT_CYC cycles in the wait states (err_o=1, y_o=0). Without it the FSM
// waits indefinitely and err_o is tied low.
module func_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [8*N_REQ-1:0] a_i,
   input  logic [8*N_REQ-1:0] b_i,
   output logic [N_REQ-1:0]   grant_o,
   output logic [N_REQ-1:0]   done_o,
   output logic [23:0]        y_o,
   output logic               err_o,
   output logic               func_start_o,
   output logic [7:0]         func_a_o,
   output logic [7:0]         func_b_o,
   input  logic               func_busy_i,
   input  logic [23:0]        func_y_i
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic [23:0]      y_q, y_d;
   logic             start_q, start_d;
   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   // Index of the current owner. The search only runs in IDLE, i.e. after the
   // previous owner's RESP, so this register also serves as last_owner.
   logic [IW-1:0]    owner_q, owner_d;

   logic [IW-1:0]    win_idx;
   logic             win_found;
   logic             wd_fire;

   // Round-robin search starting just after the last owner.
   always_comb begin
      logic [IW-1:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IW'((int'(owner_q) + i) % N_REQ);
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

`ifdef FUNC_ARB_TIMEOUT_EN
   logic [31:0] wd_cnt_q, wd_cnt_d;
   logic        err_q, err_d;

   // Watchdog fires only when the normal wait-state exit is not taken.
   assign wd_fire = (wd_cnt_q == 32'(TIMEOUT_CYC - 1)) &&
                    (((state_q == S_WAIT_BUSY) && !func_busy_i) ||
                     ((state_q == S_WAIT_DONE) &&  func_busy_i));

   // Watchdog counter and error flag next-state; err clears on a new grant.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q;
      if (state_q == S_IDLE) begin
         wd_cnt_d = '0;
         if (win_found) begin
            err_d = 1'b0;
         end
      end else if ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) begin
         wd_cnt_d = wd_cnt_q + 32'd1;
         if (wd_fire) begin
            err_d = 1'b1;
         end
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err_o = err_q;
`else
   // The limit only matters when the watchdog is built in.
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYC);
   assign wd_fire        = 1'b0;
   assign err_o          = 1'b0;
`endif

   // FSM next-state and registered-output next values.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      y_d     = y_q;
      start_d = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      owner_d = owner_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               a_d              = a_i[8*win_idx +: 8];
               b_d              = b_i[8*win_idx +: 8];
               start_d          = 1'b1;
               state_d          = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (func_busy_i) begin
               state_d = S_WAIT_DONE;
            end else if (wd_fire) begin
               y_d     = '0;
               state_d = S_RESP;
            end
         end
         S_WAIT_DONE: begin
            if (!func_busy_i) begin
               y_d     = func_y_i;
               state_d = S_RESP;
            end else if (wd_fire) begin
               y_d     = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            done_d  = grant_q;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset takes effect immediately.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         y_q     <= '0;
         start_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         owner_q <= IW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         y_q     <= y_d;
         start_q <= start_d;
         a_q     <= a_d;
         b_q     <= b_d;
         owner_q <= owner_d;
      end
   end

   assign grant_o      = grant_q;
   assign done_o       = done_q;
   assign y_o          = y_q;
   assign func_start_o = start_q;
   assign func_a_o     = a_q;
   assign func_b_o     = b_q;

endmodule

// File: tb/tb_func_arbiter.sv
// Bench for func_arbiter: transaction-level reference model checked every
// cycle, a behavioural func stub, directed scenarios with literal results,
// then randomized request traffic.
module tb_func_arbiter;

   localparam int N  = 4;
   localparam int TO = 20;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] a_v, b_v;
   logic [N-1:0]   grant_o, done_o;
   logic [23:0]    y_o;
   logic           err_o, func_start_o;
   logic [7:0]     func_a_o, func_b_o;
   logic           busy;
   logic [23:0]    fy;

   always #5 clk = ~clk;

   func_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .req_i       (req),
      .a_i         (a_v),
      .b_i         (b_v),
      .grant_o     (grant_o),
      .done_o      (done_o),
      .y_o         (y_o),
      .err_o       (err_o),
      .func_start_o(func_start_o),
      .func_a_o    (func_a_o),
      .func_b_o    (func_b_o),
      .func_busy_i (busy),
      .func_y_i    (fy)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state (transaction level)
   int          cyc = 0;
   bit          txn = 0;
   int          m_owner, m_last, m_g, m_r, m_lat;
   bit          m_to;
   int unsigned m_res;
   logic [7:0]  m_a, m_b;
   logic [23:0] e_y;
   logic        e_err;
   logic [7:0]  e_fa, e_fb;
   int          mode = 0;
   logic [N-1:0] hold = '0;
   bit          force_hang = 0;

   function automatic int unsigned fref(input int unsigned a, input int unsigned b);
      int unsigned r = 0;
      while ((r + 1) * (r + 1) <= b) r++;
      return a * a * a + r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Compare process: model outputs vs DUT every cycle, sampled on negedge.
   initial begin
      logic [N-1:0] eg, ed;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            txn = 0; m_last = N - 1;
            e_y = '0; e_err = 1'b0; e_fa = '0; e_fb = '0;
            check("rst_grant", 32'(grant_o), 0);
            check("rst_done",  32'(done_o), 0);
            check("rst_y",     32'(y_o), 0);
            check("rst_err",   32'(err_o), 0);
            check("rst_start", 32'(func_start_o), 0);
            check("rst_fa",    32'(func_a_o), 0);
            check("rst_fb",    32'(func_b_o), 0);
         end else begin
            if (txn && cyc == m_g) begin e_fa = m_a; e_fb = m_b; e_err = 1'b0; end
            if (txn && cyc == m_r) begin
               e_y = m_to ? 24'd0 : 24'(m_res);
               if (m_to) e_err = 1'b1;
            end
            eg = (txn && cyc >= m_g && cyc <= m_r) ? N'(1 << m_owner) : '0;
            ed = (txn && cyc == m_r + 1) ? N'(1 << m_owner) : '0;
            check("grant", 32'(grant_o), 32'(eg));
            check("done",  32'(done_o), 32'(ed));
            check("y",     32'(y_o), 32'(e_y));
            check("err",   32'(err_o), 32'(e_err));
            check("start", 32'(func_start_o), 32'(txn && cyc == m_g));
            check("fa",    32'(func_a_o), 32'(e_fa));
            check("fb",    32'(func_b_o), 32'(e_fb));
            if (txn && cyc == m_r + 1) begin txn = 0; m_last = m_owner; end
            if (!txn) begin
               for (int k = 1; k <= N; k++) begin
                  int idx;
                  idx = (m_last + k) % N;
                  if (!txn && req[idx]) begin
                     txn = 1; m_owner = idx; m_g = cyc + 1;
                     m_a = a_v[8*idx +: 8]; m_b = b_v[8*idx +: 8];
                     m_res = fref(m_a, m_b);
                     m_lat = $urandom_range(1, 4);
                     m_to = 0;
`ifdef FUNC_ARB_TIMEOUT_EN
                     if (force_hang || $urandom_range(0, 7) == 0) m_lat = 1000;
`endif
                     m_r = m_g + m_lat + 2;
`ifdef FUNC_ARB_TIMEOUT_EN
                     if (m_lat + 2 > TO + 1) begin m_r = m_g + TO + 1; m_to = 1; end
`endif
                  end
               end
            end
         end
         cyc++;
      end
   end

   // One clock: drive func stub, then requester behaviour.
   task automatic step();
      @(posedge clk); #1;
      busy = txn && (cyc >= m_g + 1) && (cyc <= m_g + m_lat);
      fy   = busy ? 24'($urandom) : 24'(fref(func_a_o, func_b_o));
      for (int k = 0; k < N; k++) begin
         if (mode == 0) begin
            if (done_o[k] && !hold[k]) req[k] = 1'b0;
         end else begin
            if (req[k]) begin
               if (done_o[k]) req[k] = ($urandom_range(0, 2) == 0);
               else if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               req[k] = 1'b1;
               b_v[8*k +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) a_v[8*k +: 8] = 8'($urandom);
         end
      end
   endtask

   task automatic wait_done(output logic [N-1:0] d, output logic [23:0] y);
      d = '0; y = '0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (done_o != '0) begin d = done_o; y = y_o; return; end
      end
      tests++; fails++;
      $display("FAIL wait_done cyc=%0d got=no done expected=done within 300 cycles", cyc);
   endtask

   task automatic wait_busy();
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy) return;
      end
      tests++; fails++;
      $display("FAIL wait_busy cyc=%0d got=no busy expected=busy", cyc);
   endtask

   initial begin
      logic [N-1:0] d;
      logic [23:0]  y;
      int unsigned  rr_y[4] = '{27005, 216005, 729005, 1728005};
      logic [N-1:0] ord[3]  = '{4'b0100, 4'b0010, 4'b0100};
      rst_n = 1'b0; req = '0; a_v = '0; b_v = '0; busy = 1'b0; fy = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // All four at once after reset: order 0,1,2,3
      for (int k = 0; k < N; k++) begin
         a_v[8*k +: 8] = 8'(30 * (k + 1));
         b_v[8*k +: 8] = 8'd30;
      end
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_done(d, y);
         check("rr4_done", 32'(d), 32'(1 << i));
         check("rr4_y", 32'(y), rr_y[i]);
      end
      repeat (2) step();

      // Single requester 0: 15^3 + 3
      a_v[7:0] = 8'd15; b_v[7:0] = 8'd15; req[0] = 1'b1;
      wait_done(d, y);
      check("single_done", 32'(d), 32'd1);
      check("single_y", 32'(y), 32'd3378);
      check("single_err", 32'(err_o), 32'd0);
      repeat (2) step();

      // Requester 2 holds, requester 1 asks once: order 2,1,2
      hold = 4'b0100;
      a_v[23:16] = 8'd3; b_v[23:16] = 8'd4;
      a_v[15:8]  = 8'd2; b_v[15:8]  = 8'd1;
      req[2] = 1'b1;
      step();
      req[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_done(d, y);
         check("hold_order", 32'(d), 32'(ord[i]));
      end
      hold = '0; req = '0;
      repeat (2) step();

      // Max operands, no truncation
      a_v[31:24] = 8'd255; b_v[31:24] = 8'd255; req[3] = 1'b1;
      wait_done(d, y);
      check("max_done", 32'(d), 32'b1000);
      check("max_y", 32'(y), 32'd16581390);
      repeat (2) step();

      // Operand change while waiting is ignored
      a_v[7:0] = 8'd10; b_v[7:0] = 8'd16; req[0] = 1'b1;
      wait_busy();
      step();
      a_v[7:0] = 8'd200; b_v[7:0] = 8'd0;
      wait_done(d, y);
      check("freeze_y", 32'(y), 32'd1004);
      repeat (2) step();

      // Reset during WAIT_BUSY clears outputs asynchronously
      a_v[15:8] = 8'd7; b_v[15:8] = 8'd9; req[1] = 1'b1;
      wait_busy();
      rst_n = 1'b0;
      #1;
      check("arst_grant", 32'(grant_o), 32'd0);
      check("arst_y", 32'(y_o), 32'd0);
      check("arst_fa", 32'(func_a_o), 32'd0);
      req = '0;
      repeat (2) step();
      rst_n = 1'b1;
      step();

`ifdef FUNC_ARB_TIMEOUT_EN
      // Stub never drops busy: watchdog response
      force_hang = 1; a_v[7:0] = 8'd5; req[0] = 1'b1;
      wait_done(d, y);
      check("to_err", 32'(err_o), 32'd1);
      check("to_y", 32'(y), 32'd0);
      force_hang = 0;
      repeat (2) step();
`endif

      // Random traffic
      mode = 1;
      repeat (3000) step();
      mode = 0; req = '0;
      for (int i = 0; i < 2000 && txn; i++) step();
      check("drain_idle", 32'(txn), 32'd0);
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/func_arbiter.md
# func_arbiter

Round-robin scheduler that shares one `func` unit (y = a³ + ⌊√b⌋, 8-bit operands, 24-bit result, start/busy handshake) among `N_REQ` requesters. It sits between the requesters and the `func` instance. It latches the winning requester's operands, sequences start/busy on the unit, and returns the result with a one-cycle done pulse to that requester only.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYC`, 255, watchdog limit in cycles (used only with `FUNC_ARB_TIMEOUT_EN`)

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `req_i` in N_REQ: request per requester. Held high until its `done_o` bit pulses.
- `a_i` in 8*N_REQ: packed operand a. Requester k uses [8k+7:8k].
- `b_i` in 8*N_REQ: packed operand b, same packing.
- `grant_o` out N_REQ: one-hot current owner. Zero in IDLE.
- `done_o` out N_REQ: one-cycle pulse on the owner's bit when `y_o` is valid.
- `y_o` out 24: registered result. Holds until the next completion.
- `err_o` out 1: timeout flag, valid with `done_o`. Tied 0 without the macro.
- `func_start_o` out 1: start pulse to `func`.
- `func_a_o` out 8: latched operand a.
- `func_b_o` out 8: latched operand b.
- `func_busy_i` in 1: `func` busy.
- `func_y_i` in 24: `func` result.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any `req_i` bit is high, pick the winner round-robin.
  - Search starts at (last_owner+1) mod N_REQ. last_owner resets to N_REQ-1, so requester 0 wins first after reset.
  - Register the one-hot grant, latch the winner's a/b into `func_a_o`/`func_b_o`, go to ISSUE.
- ISSUE: `func_start_o`=1 for exactly one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for `func_busy_i`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `func_busy_i`=0. On that cycle, capture `func_y_i` into `y_o` and go to RESP.
- RESP: `done_o`=grant for one cycle. Update last_owner, clear grant, go to IDLE.
- Operands are frozen from grant until RESP. Requester changes to `a_i`/`b_i` during that window are ignored.
- A requester that drops `req_i` mid-operation does not abort it. The result and `done_o` are still delivered.
- A requester still asserting `req_i` after its done is treated as a new request. Other pending requesters win first.
- No arithmetic is done here. `y_o` is `func_y_i` passed through unmodified, full 24 bits.

## Timing
- Reset values: `grant_o`=0, `done_o`=0, `y_o`=0, `err_o`=0, `func_start_o`=0, `func_a_o`=0, `func_b_o`=0, state=IDLE.
- Reset mid-operation clears everything immediately. `func` is reset separately by its own owner.
- req seen in IDLE at cycle 0:
  - `grant_o` valid at cycle 1.
  - `func_start_o` high at cycle 1.
  - `done_o` pulses 2 cycles after the cycle where `func_busy_i` falls.
- Minimum 1 IDLE cycle between back-to-back operations.
- All outputs are registered. There is no combinational path from `req_i` to any output.

## Configuration
- `FUNC_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE.
  - If it reaches `TIMEOUT_CYC`, the FSM goes to RESP with `err_o`=1 and `y_o`=0.
  - `err_o` clears when the next operation is granted.
- Not defined: the FSM waits indefinitely, and `err_o` is constant 0.

## Test plan
- Single requester 0 with a=15, b=15 → `done_o`=0001, `y_o`=3378, `err_o`=0.
- Requesters 0..3 all request at once, with a=30/60/90/120 and b=30 → grants in order 0,1,2,3. Results 27005, 216005, 729005, 1728005, each paired with its own done bit.
- Requester 2 holds `req_i` continuously while requester 1 requests once → grant order 2,1,2. Requester 2 is never starved.
- Max operands a=255, b=255 → `y_o`=16581390 with no truncation.
- Change `a_i` during WAIT_DONE, and assert `rst_i`=0 during WAIT_BUSY → the result reflects the latched operand. Reset returns all outputs to 0 asynchronously.
- With `FUNC_ARB_TIMEOUT_EN` and a stubbed `func` whose busy never falls → RESP at `TIMEOUT_CYC` with `err_o`=1 and `y_o`=0.
